// File: rtl/pio_loader_if.sv
// pio_loader_if: bundles the runtime push handshake and the PIO command bus.
//   push_valid/push_mindex/push_data : client word to push into a TX FIFO
//   push_ready                       : loader accepts when valid & ready
//   tx_full                          : per-machine TX-FIFO-full flags from pio
//   action/index/mindex/din          : command bus driven into the pio
// master = the loader, slave = the client/pio side.
interface pio_loader_if;
  logic        push_valid;
  logic [1:0]  push_mindex;
  logic [31:0] push_data;
  logic        push_ready;
  logic [3:0]  tx_full;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;

  modport master (
    input  push_valid, push_mindex, push_data, tx_full,
    output push_ready, action, index, mindex, din
  );

  modport slave (
    output push_valid, push_mindex, push_data, tx_full,
    input  push_ready, action, index, mindex, din
  );
endinterface

// File: rtl/pio_loader.sv
// pio_loader: sole driver of the PIO command bus. After reset it streams the
// program ROM into instruction memory (action 1), replays the config ROM
// entries, then sits in RUN forwarding client pushes (action 4).
//   clk, n_reset      : clock, async active-low reset
//   restart           : in RUN, reload program and config
//   prog_addr/data    : program ROM, synchronous 1-cycle read
//   conf_addr/data    : config ROM {mindex[37:36], action[35:32], din[31:0]}
//   loaded            : high only while in RUN
//   bus               : push handshake + command bus (master side)
module pio_loader #(
  parameter int unsigned PROG_LEN = 32,
  parameter int unsigned CONF_LEN = 10
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        restart,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  conf_addr,
  input  logic [37:0] conf_data,
  output logic        loaded,
  pio_loader_if.master bus
);

  localparam int unsigned AW        = 5;
  localparam logic [AW-1:0] PROG_LAST = AW'(PROG_LEN - 1);
  localparam logic [AW-1:0] CONF_LAST = AW'(CONF_LEN - 1);
  localparam logic [3:0] ACT_NONE = 4'd0;
  localparam logic [3:0] ACT_LOAD = 4'd1;
  localparam logic [3:0] ACT_PUSH = 4'd4;

  // DRAIN/SETTLE cover the 2-cycle ROM-to-command latency of the last entry
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONF, S_DRAIN, S_SETTLE, S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] prog_addr_q, prog_addr_d;
  logic [AW-1:0] conf_addr_q, conf_addr_d;
  // stage between address issue and command: ROM data is valid this cycle
  logic          pipe_vld_q, pipe_vld_d;
  logic          pipe_conf_q, pipe_conf_d;
  logic [AW-1:0] pipe_idx_q, pipe_idx_d;
  logic [3:0]    action_q, action_d;
  logic [AW-1:0] index_q, index_d;
  logic [1:0]    mindex_q, mindex_d;
  logic [31:0]   din_q, din_d;
  logic          loaded_q, loaded_d;
  // blocks the cycle after an accept so the pio's tx_full can catch up
  logic          push_gap_q, push_gap_d;
  logic          push_ready_c;
  logic          push_accept_c;

  assign push_ready_c  = (state_q == S_RUN) & ~bus.tx_full[bus.push_mindex] & ~push_gap_q;
  assign push_accept_c = bus.push_valid & push_ready_c;

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      prog_addr_q <= '0;
      conf_addr_q <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_conf_q <= 1'b0;
      pipe_idx_q  <= '0;
      action_q    <= ACT_NONE;
      index_q     <= '0;
      mindex_q    <= '0;
      din_q       <= '0;
      loaded_q    <= 1'b0;
      push_gap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      conf_addr_q <= conf_addr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_conf_q <= pipe_conf_d;
      pipe_idx_q  <= pipe_idx_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
      loaded_q    <= loaded_d;
      push_gap_q  <= push_gap_d;
    end
  end

  // Next-state, address stepping and next command
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    conf_addr_d = conf_addr_q;
    pipe_vld_d  = 1'b0;
    pipe_conf_d = 1'b0;
    pipe_idx_d  = '0;
    action_d    = ACT_NONE;
    index_d     = '0;
    mindex_d    = '0;
    din_d       = '0;
    push_gap_d  = push_accept_c;

    unique case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        pipe_vld_d = 1'b1;
        pipe_idx_d = prog_addr_q;
        if (prog_addr_q == PROG_LAST) state_d = S_CONF;
        else prog_addr_d = prog_addr_q + AW'(1);
      end
      S_CONF: begin
        pipe_vld_d  = 1'b1;
        pipe_conf_d = 1'b1;
        if (conf_addr_q == CONF_LAST) state_d = S_DRAIN;
        else conf_addr_d = conf_addr_q + AW'(1);
      end
      S_DRAIN:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (restart) begin
          state_d     = S_IDLE;
          prog_addr_d = '0;
          conf_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ROM data arriving this cycle becomes next cycle's command
    if (pipe_vld_q) begin
      if (pipe_conf_q) begin
        action_d = conf_data[35:32];
        mindex_d = conf_data[37:36];
        din_d    = conf_data[31:0];
      end else begin
        action_d = ACT_LOAD;
        index_d  = pipe_idx_q;
        din_d    = {16'h0, prog_data};
      end
    end

    // Pipeline is empty in RUN, so a push never collides with a ROM command
    if (push_accept_c) begin
      action_d = ACT_PUSH;
      index_d  = '0;
      mindex_d = bus.push_mindex;
      din_d    = bus.push_data;
    end

    loaded_d = (state_d == S_RUN);
  end

  assign prog_addr      = prog_addr_q;
  assign conf_addr      = conf_addr_q;
  assign loaded         = loaded_q;
  assign bus.push_ready = push_ready_c;
  assign bus.action     = action_q;
  assign bus.index      = index_q;
  assign bus.mindex     = mindex_q;
  assign bus.din        = din_q;

endmodule

// File: tb/tb_pio_loader.sv
// tb_pio_loader: directed bench for pio_loader with synchronous ROM models,
// covering boot load, config replay, push pacing, tx_full back-pressure,
// restart and a mid-load reset.
module tb_pio_loader;

  logic        clk;
  logic        n_reset;
  logic        restart;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [4:0]  conf_addr;
  logic [37:0] conf_data;
  logic        loaded;

  logic [15:0] prog_rom [32];
  logic [37:0] conf_rom [32];

  int vectors;
  int miscompares;

  pio_loader_if bus ();

  pio_loader #(.PROG_LEN(32), .CONF_LEN(10)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .restart   (restart),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .conf_addr (conf_addr),
    .conf_data (conf_data),
    .loaded    (loaded),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs with one cycle of read latency
  always @(posedge clk) begin
    prog_data <= prog_rom[prog_addr];
    conf_data <= conf_rom[conf_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] cmd(input logic [3:0] a, input logic [4:0] i,
                                      input logic [1:0] m, input logic [31:0] d);
    return 64'({a, i, m, d});
  endfunction

  function automatic logic [63:0] obs_cmd();
    return 64'({bus.action, bus.index, bus.mindex, bus.din});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle; returns in the first RUN cycle
  task automatic expect_full_load(input string tag);
    logic [37:0] e;
    tick();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s fill%0d", tag, c), obs_cmd(), 64'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s load%0d", tag, i), obs_cmd(),
            cmd(4'd1, 5'(i), 2'd0, {16'h0, prog_rom[i]}));
      check($sformatf("%s load%0d ld/rdy", tag, i), 64'({loaded, bus.push_ready}), 64'd0);
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      e = conf_rom[j];
      check($sformatf("%s conf%0d", tag, j), obs_cmd(), cmd(e[35:32], 5'd0, e[37:36], e[31:0]));
      check($sformatf("%s conf%0d ld/rdy", tag, j), 64'({loaded, bus.push_ready}), 64'd0);
      tick();
    end
    check($sformatf("%s run loaded", tag), 64'(loaded), 64'd1);
    check($sformatf("%s run idle bus", tag), obs_cmd(), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      prog_rom[i] = 16'(16'hE003 + (i * 16'h0111));
      conf_rom[i] = '0;
    end
    conf_rom[0] = {2'd0, 4'd3, 32'h0000_0010};
    conf_rom[1] = {2'd2, 4'd0, 32'hDEAD_BEEF};
    conf_rom[2] = {2'd3, 4'd5, 32'h0000_00FF};
    conf_rom[3] = {2'd1, 4'd2, 32'h0000_1234};
    conf_rom[4] = {2'd0, 4'd6, 32'h8000_0001};
    conf_rom[5] = {2'd1, 4'd7, 32'h0000_0000};
    conf_rom[6] = {2'd2, 4'd3, 32'hA5A5_5A5A};
    conf_rom[7] = {2'd3, 4'd0, 32'h0000_0000};
    conf_rom[8] = {2'd0, 4'd8, 32'h0000_0003};
    conf_rom[9] = {2'd1, 4'd4, 32'h0001_0002};

    n_reset         = 1'b0;
    restart         = 1'b0;
    bus.push_valid  = 1'b0;
    bus.push_mindex = 2'd0;
    bus.push_data   = 32'd0;
    bus.tx_full     = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd", obs_cmd(), 64'd0);
    check("rst ld/rdy", 64'({loaded, bus.push_ready}), 64'd0);
    check("rst addrs", 64'({prog_addr, conf_addr}), 64'd0);

    // Client pushes before boot completes: must wait for RUN
    bus.push_valid = 1'b1;
    bus.push_data  = 32'd5;
    @(posedge clk);
    #1 n_reset = 1'b1;
    expect_full_load("boot");
    check("conf entry3", 64'(conf_rom[3]), 64'({2'd1, 4'd2, 32'h1234}));
    check("addr stop", 64'({prog_addr, conf_addr}), 64'({5'd31, 5'd9}));
    check("first ready", 64'(bus.push_ready), 64'd1);

    // Back-to-back pushes 5, 6, 7 come out on alternate cycles
    tick();
    check("push5", obs_cmd(), cmd(4'd4, 5'd0, 2'd0, 32'd5));
    check("gap5", 64'(bus.push_ready), 64'd0);
    bus.push_data = 32'd6;
    tick();
    check("idle5", obs_cmd(), 64'd0);
    check("rdy6", 64'(bus.push_ready), 64'd1);
    tick();
    check("push6", obs_cmd(), cmd(4'd4, 5'd0, 2'd0, 32'd6));
    check("gap6", 64'(bus.push_ready), 64'd0);
    bus.push_data = 32'd7;
    tick();
    check("idle6", obs_cmd(), 64'd0);
    tick();
    check("push7", obs_cmd(), cmd(4'd4, 5'd0, 2'd0, 32'd7));
    bus.push_valid = 1'b0;
    tick();
    check("idle7", obs_cmd(), 64'd0);

    // Back-pressure on machine 2
    bus.push_valid  = 1'b1;
    bus.push_mindex = 2'd2;
    bus.push_data   = 32'hCAFE_0002;
    bus.tx_full     = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("full rdy%0d", k), 64'(bus.push_ready), 64'd0);
      check($sformatf("full cmd%0d", k), obs_cmd(), 64'd0);
      tick();
    end
    // Other machines full does not block machine 2
    bus.tx_full = 4'b1011;
    #1;
    check("unfull rdy", 64'(bus.push_ready), 64'd1);
    tick();
    check("unfull push", obs_cmd(), cmd(4'd4, 5'd0, 2'd2, 32'hCAFE_0002));
    bus.push_valid = 1'b0;
    bus.tx_full    = 4'd0;
    tick();
    check("unfull idle", obs_cmd(), 64'd0);

    // Restart with a simultaneous push: push still issued, then full reload
    bus.push_valid  = 1'b1;
    bus.push_mindex = 2'd3;
    bus.push_data   = 32'h77;
    restart         = 1'b1;
    #1;
    check("rs rdy", 64'(bus.push_ready), 64'd1);
    tick();
    restart        = 1'b0;
    bus.push_valid = 1'b0;
    check("rs loaded", 64'(loaded), 64'd0);
    check("rs push", obs_cmd(), cmd(4'd4, 5'd0, 2'd3, 32'h77));
    expect_full_load("restart");

    // Restart outside RUN is ignored; reset pulsed mid-load at index 12
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs2 loaded", 64'(loaded), 64'd0);
    restart = 1'b1;
    repeat (15) tick();
    restart = 1'b0;
    check("mid idx12", obs_cmd(), cmd(4'd1, 5'd12, 2'd0, {16'h0, prog_rom[12]}));
    n_reset = 1'b0;
    #1;
    check("mid rst cmd", obs_cmd(), 64'd0);
    check("mid rst addr", 64'({prog_addr, conf_addr, loaded}), 64'd0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    expect_full_load("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
